// File: rtl/adc_links_pkg.sv
// Shared types, widths and helpers for the left-channel ADC SPI capture block.
package adc_links_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_XFER, ST_DONE} state_t;

   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned SAMPLE_W   = 12;
   localparam int unsigned CNT_MSB    = 31;
   localparam int unsigned CNT_LSB    = 24;
   localparam int unsigned SMP_MSB    = 11;
   localparam int unsigned CNT_W      = CNT_MSB - CNT_LSB + 1;
   localparam int unsigned PAD_W      = CNT_LSB - SMP_MSB - 1;

   // Layout of the word presented to the PIO in_port
   typedef struct packed {
      logic [CNT_W-1:0]    cnt;
      logic [PAD_W-1:0]    pad;
      logic [SAMPLE_W-1:0] sample;
   } sample_word_t;

   function automatic logic [FRAME_BITS-1:0] din_word(input logic [2:0] channel);
      return {2'b00, channel, 11'b0};
   endfunction

endpackage

// File: rtl/adc_links_sclk_gen.sv
// SCLK generator: toggles sclk every CLK_DIV clks while enabled, idles high.
module adc_links_sclk_gen #(
   parameter int unsigned CLK_DIV = 25
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic sclk,
   output logic rise_en,
   output logic fall_en
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV);

   logic [DIV_W-1:0] cnt;
   logic             tick;

   // Strobes mark the clk edge on which sclk changes level
   assign tick    = en && (cnt == DIV_W'(CLK_DIV - 1));
   assign rise_en = tick && !sclk;
   assign fall_en = tick && sclk;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         sclk <= 1'b1;
      end else if (!en) begin
         cnt  <= '0;
         sclk <= 1'b1;
      end else if (tick) begin
         cnt  <= '0;
         sclk <= ~sclk;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/adc_links_spi_capture.sv
// Periodic ADC128S022-style SPI frame engine feeding the left-channel PIO word.
// Optional 4-sample averaging when ADC_AVG_EN is defined.
module adc_links_spi_capture
   import adc_links_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 25,
   parameter int unsigned SAMPLE_DIV = 1250,
   parameter int unsigned CHANNEL    = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        adc_cs_n,
   output logic        adc_sclk,
   output logic        adc_din,
   input  logic        adc_dout,
   output logic [31:0] sample_word,
   output logic        sample_valid
);

   localparam int unsigned TMR_W = $clog2(SAMPLE_DIV);
   localparam int unsigned BIT_W = $clog2(FRAME_BITS);

   state_t                state;
   logic [TMR_W-1:0]      timer;
   logic [BIT_W-1:0]      bit_cnt;
   logic [FRAME_BITS-1:0] tx_shift;
   logic [FRAME_BITS-1:0] rx_shift;
   logic                  first;
   logic [CNT_W-1:0]      frame_cnt;
   logic                  expire_c;
   logic                  sclk_en_c;
   logic                  rise_en;
   logic                  fall_en;
   logic                  publish_c;
   logic                  frame_ok_c;
   logic [SAMPLE_W-1:0]   smp_c;
   sample_word_t          next_word_c;
   logic                  unused_rx_c;

   // The ADC's leading bits carry no data
   assign unused_rx_c = ^rx_shift[FRAME_BITS-1:SAMPLE_W];

   assign expire_c   = (timer == TMR_W'(SAMPLE_DIV - 1));
   assign sclk_en_c  = (state == ST_START) || (state == ST_XFER);
   assign frame_ok_c = (state == ST_DONE) && !first;

   adc_links_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (sclk_en_c),
      .sclk    (adc_sclk),
      .rise_en (rise_en),
      .fall_en (fall_en)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      timer <= '0;
      else if (expire_c) timer <= '0;
      else               timer <= timer + TMR_W'(1);
   end

`ifdef ADC_AVG_EN
   localparam int unsigned ACC_W = SAMPLE_W + 2;

   logic [ACC_W-1:0] acc;
   logic [1:0]       avg_n;
   logic [ACC_W-1:0] sum_c;

   always_comb begin
      sum_c     = acc + ACC_W'(rx_shift[SAMPLE_W-1:0]);
      publish_c = (avg_n == 2'd3);
      smp_c     = sum_c[ACC_W-1:2];
   end

   // Accumulate every kept frame; clear on the fourth
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc   <= '0;
         avg_n <= '0;
      end else if (frame_ok_c) begin
         acc   <= publish_c ? '0 : sum_c;
         avg_n <= avg_n + 2'd1;
      end
   end
`else
   always_comb begin
      publish_c = 1'b1;
      smp_c     = rx_shift[SAMPLE_W-1:0];
   end
`endif

   always_comb begin
      next_word_c.cnt    = frame_cnt + CNT_W'(1);
      next_word_c.pad    = '0;
      next_word_c.sample = smp_c;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         adc_cs_n     <= 1'b1;
         adc_din      <= 1'b0;
         tx_shift     <= '0;
         rx_shift     <= '0;
         bit_cnt      <= '0;
         first        <= 1'b1;
         frame_cnt    <= '0;
         sample_word  <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (expire_c) begin
                  state    <= ST_START;
                  adc_cs_n <= 1'b0;
                  tx_shift <= din_word(3'(CHANNEL));
                  bit_cnt  <= '0;
               end
            end
            ST_START: begin
               if (fall_en) begin
                  state    <= ST_XFER;
                  adc_din  <= tx_shift[FRAME_BITS-1];
                  tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
               end
            end
            ST_XFER: begin
               if (fall_en) begin
                  adc_din  <= tx_shift[FRAME_BITS-1];
                  tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
               end
               if (rise_en) begin
                  rx_shift <= {rx_shift[FRAME_BITS-2:0], adc_dout};
                  bit_cnt  <= bit_cnt + BIT_W'(1);
                  // 16th rising edge closes the frame together with sclk high
                  if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                     state    <= ST_DONE;
                     adc_cs_n <= 1'b1;
                     adc_din  <= 1'b0;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               first <= 1'b0;
               if (frame_ok_c && publish_c) begin
                  sample_word  <= next_word_c;
                  sample_valid <= 1'b1;
                  frame_cnt    <= frame_cnt + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
